// File: rtl/create_matrix.sv
// create_matrix: registered 16x32 LED frame generator with static, bar-graph and scrolling-column screens
module create_matrix #(
  parameter int SCROLL_DIV_BITS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  screen,
  output logic [31:0] matrix [16]
);
  localparam int CW = (SCROLL_DIV_BITS > 0) ? SCROLL_DIV_BITS : 1;
  logic [CW-1:0] cnt;
  logic [4:0]    p;
  logic [31:0]   nxt [16];
  logic [31:0]   bar;
  logic          scroll;
  logic          wrap;
  assign scroll = screen == 6'd6;
  assign wrap   = (SCROLL_DIV_BITS == 0) | (&cnt);
  // 2<<n wraps to 0 for n=31, so subtracting 1 yields all-ones without a wider adder
  assign bar    = (32'h2 << screen[4:0]) - 32'h1;
  always_comb begin
    for (int r = 0; r < 16; r++) begin
      nxt[r] = screen[5]      ? bar :
               screen == 6'd1 ? 32'hFFFF_FFFF :
               screen == 6'd2 ? (r[0] ? 32'h5555_5555 : 32'hAAAA_AAAA) :
               screen == 6'd3 ? ((r == 0 || r == 15) ? 32'hFFFF_FFFF : 32'h8000_0001) :
               screen == 6'd4 ? (r[0] ? 32'h0000_0000 : 32'hFFFF_FFFF) :
               screen == 6'd5 ? 32'h0F0F_0F0F :
               scroll         ? (32'h1 << p) :
                                32'h0000_0000;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      matrix <= '{default: '0};
      cnt    <= '0;
      p      <= '0;
    end else begin
      matrix <= nxt;
      cnt    <= scroll ? cnt + CW'(1) : '0;
      p      <= scroll ? (wrap ? p + 5'd1 : p) : 5'd0;
    end
  end
endmodule

// File: tb/tb_create_matrix.sv
// tb_create_matrix: scoreboard bench driving two create_matrix instances (scroll divider 0 and 2)
module tb_create_matrix;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  screen = 6'd1;
  logic [31:0] m0 [16];
  logic [31:0] m2 [16];
  int          vectors = 0;
  int          miscompares = 0;
  typedef struct packed {
    logic [15:0][31:0] e0;
    logic [15:0][31:0] e2;
  } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  create_matrix #(.SCROLL_DIV_BITS(0)) d0 (.clk(clk), .reset(reset), .screen(screen), .matrix(m0));
  create_matrix #(.SCROLL_DIV_BITS(2)) d2 (.clk(clk), .reset(reset), .screen(screen), .matrix(m2));
  function automatic logic [15:0][31:0] mk(input logic [31:0] top, even, odd, bottom);
    logic [15:0][31:0] v;
    for (int r = 0; r < 16; r++) v[r] = r[0] ? odd : even;
    v[0]  = top;
    v[15] = bottom;
    return v;
  endfunction
  function automatic logic [15:0][31:0] all(input logic [31:0] w);
    return mk(w, w, w, w);
  endfunction
  task automatic apply(input logic rst, input logic [5:0] s, input logic [15:0][31:0] x0, input logic [15:0][31:0] x2);
    exp_t e;
    @(negedge clk);
    reset = rst;
    screen = s;
    e.e0 = x0;
    e.e2 = x2;
    q.push_back(e);
  endtask
  task automatic same(input logic rst, input logic [5:0] s, input logic [15:0][31:0] x);
    apply(rst, s, x, x);
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors += 2;
      for (int r = 0; r < 16; r++) if (m0[r] !== e.e0[r]) begin
        miscompares++;
        $display("FAIL div0 vec %0d row %0d: got %h expected %h", vectors / 2, r, m0[r], e.e0[r]);
        break;
      end
      for (int r = 0; r < 16; r++) if (m2[r] !== e.e2[r]) begin
        miscompares++;
        $display("FAIL div2 vec %0d row %0d: got %h expected %h", vectors / 2, r, m2[r], e.e2[r]);
        break;
      end
    end
  end
  initial begin
    same(1'b1, 6'd1, all(32'h0));
    same(1'b1, 6'd1, all(32'h0));
    same(1'b0, 6'd1, all(32'hFFFFFFFF));
    repeat (3) same(1'b0, 6'd0, all(32'h0));
    repeat (3) same(1'b0, 6'd2, mk(32'hAAAAAAAA, 32'hAAAAAAAA, 32'h55555555, 32'h55555555));
    repeat (3) same(1'b0, 6'd3, mk(32'hFFFFFFFF, 32'h80000001, 32'h80000001, 32'hFFFFFFFF));
    same(1'b0, 6'd4, mk(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0));
    same(1'b0, 6'd5, all(32'h0F0F0F0F));
    same(1'b0, 6'd32, all(32'h00000001));
    same(1'b0, 6'd47, all(32'h0000FFFF));
    same(1'b0, 6'd63, all(32'hFFFFFFFF));
    same(1'b0, 6'd33, all(32'h00000003));
    same(1'b0, 6'd20, all(32'h0));
    same(1'b0, 6'd7, all(32'h0));
    for (int k = 0; k < 34; k++) apply(1'b0, 6'd6, all(32'h1 << (k % 32)), all(32'h1 << (k / 4)));
    same(1'b0, 6'd4, mk(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0));
    for (int k = 0; k < 10; k++) apply(1'b0, 6'd6, all(32'h1 << k), all(32'h1 << (k / 4)));
    same(1'b1, 6'd6, all(32'h0));
    for (int k = 0; k < 5; k++) apply(1'b0, 6'd6, all(32'h1 << k), all(32'h1 << (k / 4)));
    same(1'b0, 6'd0, all(32'h0));
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected frames never checked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/create_matrix.md
Name: create_matrix

Overview:
- Frame generator for the 32x16 LED matrix display path.
- Converts a 6-bit screen-select code into a full 16-row x 32-column bitmap, registered on the system clock.
- The downstream row-scan driver consumes it.
- Static test patterns, a bar-graph mode and one animated scrolling-column pattern are supported.

Parameters:
- SCROLL_DIV_BITS, default 20: log2 of the number of clk cycles between column advances in scroll mode (screen 6); a value of 0 advances every cycle.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- screen  input  6  screen-select code; sampled every cycle.
- matrix  output  16 x 32 (unpacked array of 16 words, 32 bits each)  frame bitmap.
  - matrix[r] is row r (0 = top, 15 = bottom).
  - Bit c is column c (bit 0 = column 0); 1 = LED on.

Behaviour:
- Fully registered output. On each rising clk edge, matrix is loaded with the pattern for the screen value present at that edge. Latency is 1 cycle; there is no handshake.
- Reset, when sampled high on an edge:
  - All 16 matrix rows = 32'h00000000.
  - Scroll position = 0; divider counter = 0.
  - Reset has priority over all pattern logic.
- Pattern decode (applies to every row r unless stated):
  - screen 0: blank, all rows 32'h00000000.
  - screen 1: all on, all rows 32'hFFFFFFFF.
  - screen 2: checkerboard, bit c = r[0] XOR c[0]. Even rows = 32'hAAAAAAAA; odd rows = 32'h55555555.
  - screen 3: border. Rows 0 and 15 = 32'hFFFFFFFF; rows 1–14 = 32'h80000001.
  - screen 4: horizontal stripes. Even rows = 32'hFFFFFFFF; odd rows = 32'h00000000.
  - screen 5: vertical stripes, all rows 32'h0F0F0F0F.
  - screen 6: scrolling column. All rows = (32'h1 << p), where p is the 5-bit scroll position.
  - screens 7–31: reserved; output blank (all zero).
  - screens 32–63 (screen[5]=1): bar graph with n = screen[4:0]. Every row has columns 0..n set, i.e. (2^(n+1))−1. n=0 gives 32'h00000001; n=31 gives 32'hFFFFFFFF (no overflow; compute in ≥33 bits or special-case).
- Scroll machinery:
  - A SCROLL_DIV_BITS-wide divider counter increments every cycle while screen==6.
  - When the counter wraps to 0, p increments by 1; p wraps from 31 to 0.
  - With SCROLL_DIV_BITS=0, p increments every cycle.
  - Whenever screen≠6, counter and p are held at 0, so entering screen 6 always starts at column 0.
  - First frame after entering screen 6: rows = 32'h00000001.
- Screen changes take effect on the next edge; there is no blanking frame or glitch between patterns.
- Reset asserted mid-scroll clears p. After reset deasserts with screen==6, the first output is column 0.
- The matrix value is stable between edges; there are no combinational paths from screen to matrix.

Test Plan:
- Assert reset for 2 cycles with screen=1, then deassert → matrix all 32'h00000000 during reset; all 32'hFFFFFFFF on the first edge after deassert.
- screen=0, then 2, then 3, each held 3 cycles → all zero; then row0=32'hAAAAAAAA, row1=32'h55555555, row15=32'h55555555; then row0=row15=32'hFFFFFFFF, row7=32'h80000001. Each change is visible exactly 1 edge after it is applied.
- screen=32, 47, 63 → every row = 32'h00000001, 32'h0000FFFF, 32'hFFFFFFFF respectively; screen=20 (reserved) → all zero.
- SCROLL_DIV_BITS=0, screen=6 for 34 cycles → rows step 32'h00000001, 32'h00000002, … 32'h80000000, then wrap to 32'h00000001.
- SCROLL_DIV_BITS=2, screen=6 → each column is held 4 cycles. Switch to screen 4 for one cycle, then back to 6 → output restarts at 32'h00000001.
- Reset asserted while scrolling at p=10 → matrix zero. After release with screen=6, the first output is 32'h00000001.
